write_s_block: RTL and testbench
================================

Name: write_s_block

Overview:
- Drains one finished 8x8 S block from the upper half of the dual-port RAM and writes it to external SRAM.
- S is produced by the matrix-multiply stage; each value is scaled, clipped to an 8-bit pixel, and packed two pixels per 16-bit SRAM word.
- Sits on the write side of the IDCT datapath, after MATRIX_MULT, and is started by the top-level decode FSM once per block.

Parameters:
- S_BASE, 64: DP-RAM address of S[0][0]; S[r][c] lives at S_BASE + 8*r + c.
- S_SHIFT, 16: arithmetic right shift applied to each signed 32-bit S value before clipping.
- SRAM_BASE, 0: SRAM word address of the image-plane origin.
- LINE_WORDS, 160: SRAM words per image line (320 pixels / 2).

Ports:
- CLOCK_50_I  in  1  50 MHz clock.
- Resetn  in  1  reset, asynchronous, active-low.
- WS_start  in  1  level; sampled only in idle.
- WS_done  out  1  one-cycle pulse when the last word is written.
- block_row  in  5  block row 0..29; sampled at start.
- block_col  in  6  block column 0..39; sampled at start.
- dp_address  out  7  DP-RAM port address.
- dp_read_data  in  32  DP-RAM data; valid the cycle after the address.
- dp_write_data  out  32  tied 32'd0.
- dp_write_enable  out  1  tied 0; this block never writes the DP-RAM.
- SRAM_address  out  18  SRAM word address.
- SRAM_write_data  out  16  {even pixel[7:0], odd pixel[7:0]}.
- SRAM_we_n  out  1  active-low write strobe.

Behaviour:
- Reset values: WS_done=0, dp_address=S_BASE, SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1. State goes to WS_IDLE.
- Reset mid-block: SRAM_we_n deasserts immediately (asynchronous). The partial block is abandoned. No done pulse.
- States and transitions:
  - WS_IDLE: on WS_start=1, latch block_row/block_col, clear pixel counter p (6 bits), go to WS_LI.
  - WS_LI (1 cycle): present dp_address=S_BASE+0, go to WS_RUN.
  - WS_RUN: each cycle present dp_address=S_BASE+p+1 while p<63, and consume the data for the previous address.
    - Even pixel data: clip and hold it.
    - Odd pixel data: register the SRAM write for the following cycle.
    - When the data for p=63 is consumed, go to WS_LO.
  - WS_LO (1 cycle): last write visible; go to WS_DONE.
  - WS_DONE (1 cycle): WS_done=1, SRAM_we_n=1, return to WS_IDLE.
- Timing, with cycle 0 being start acceptance:
  - DP addresses appear in cycles 1..64.
  - SRAM writes (we_n=0) occur in cycles 4,6,...,66: 32 writes total.
  - SRAM_we_n=1 in all other cycles.
  - WS_done pulses in cycle 67.
- SRAM address for pixel pair (r, c even) = SRAM_BASE + (8*block_row + r)*LINE_WORDS + 4*block_col + c/2. Compute in at least 18 bits; no wrap inside the legal block range.
- Pixel conversion:
  - v = S >>> S_SHIFT (signed).
  - Saturation: v<0 gives 0; v>255 gives 255; otherwise v[7:0].
- WS_start asserted while not idle is ignored.
- WS_start held high through WS_DONE restarts the block in the cycle after return to idle.
- block_row/col changes after start have no effect.

Optional Feature:
- Macro: WS_SATURATE_EN.
- Defined: saturation as above.
- Undefined: pixel = v[7:0] with no clip (raw wrap). Used for bit-exact debug against the software transform dump.
- Timing is identical in both builds.

Decomposition:
- Shared package/header (alongside define_state.h):
  - ws_state_type enum: WS_IDLE, WS_LI, WS_RUN, WS_LO, WS_DONE.
  - Constants: S_BASE, LINE_WORDS, image width 320.
- One natural sub-module: pixel_clip (combinational, 32-bit signed in, 8-bit out; contains the WS_SATURATE_EN switch).
- Address generation and the FSM stay in write_s_block.

Test Plan:
- S[r][c] = ((8r+c)<<16), block (0,0), saturation on -> 32 writes at addresses 0..3, 160..163, ..., 1120..1123. Word 0 = 16'h0001; last word = 16'h3E3F. WS_done in cycle 67.
- All S = 32'hFFFF0000 (-1 after shift) -> every word 16'h0000. Same values with WS_SATURATE_EN undefined -> every word 16'hFFFF.
- All S = 300<<16 -> words 16'hFFFF (saturate). Without the macro -> 16'h2C2C.
- Block (29,39) -> first address 232*160+156 = 37276, last 239*160+159 = 38399.
- Resetn low at cycle 20 -> SRAM_we_n=1 at once, no WS_done. A fresh WS_start rewrites the full block correctly.
- WS_start pulsed at cycles 10 and 40 of a block -> ignored; exactly 32 writes and one done pulse.

Source files
------------

// File: rtl/write_s_block_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_s_block_pkg
// Description : Shared types and constants for the S-block write-back stage
//               of the IDCT datapath. It holds the write-side FSM state
//               encoding, the bus field types, and the default geometry
//               constants.
//               WS_SATURATE_EN, the clipping option, is defined and used in
//               write_s_block_pixel_clip. It is not referenced in this file.
// Revision    : 1.0 - initial release
// ============================================================================
package write_s_block_pkg;

  // Write-side FSM states. The encoding is explicit so the state register
  // reads clearly in debug dumps.
  typedef enum logic [2:0] {
    WS_IDLE = 3'd0,
    WS_LI   = 3'd1,
    WS_RUN  = 3'd2,
    WS_LO   = 3'd3,
    WS_DONE = 3'd4
  } ws_state_type;

  typedef logic [6:0]  dp_addr_t;
  typedef logic [17:0] sram_addr_t;

  localparam int WS_IMG_WIDTH  = 320;
  localparam int WS_LINE_WORDS = WS_IMG_WIDTH / 2;  // two pixels per word
  localparam int WS_S_BASE     = 64;                // S lives in upper DP-RAM half
  localparam int WS_S_SHIFT    = 16;
  localparam int WS_SRAM_BASE  = 0;

endpackage
`default_nettype wire

// File: rtl/write_s_block_if.sv
`default_nettype none
// ============================================================================
// Module      : write_s_block_if
// Description : Bundles the start/done handshake, the DP-RAM port and the
//               SRAM write port of the S-block writer.
//   master : the sequencer side. It drives start, block coordinates and
//            DP-RAM read data.
//   slave  : write_s_block. It drives done, the DP-RAM address/write port
//            and the SRAM port.
// Revision    : 1.0 - initial release
// ============================================================================
interface write_s_block_if;
  import write_s_block_pkg::*;

  logic        WS_start;
  logic        WS_done;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  dp_addr_t    dp_address;
  logic [31:0] dp_read_data;
  logic [31:0] dp_write_data;
  logic        dp_write_enable;
  sram_addr_t  SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    output WS_start, block_row, block_col, dp_read_data,
    input  WS_done, dp_address, dp_write_data, dp_write_enable,
           SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    input  WS_start, block_row, block_col, dp_read_data,
    output WS_done, dp_address, dp_write_data, dp_write_enable,
           SRAM_address, SRAM_write_data, SRAM_we_n
  );

endinterface
`default_nettype wire

// File: rtl/write_s_block_pixel_clip.sv
`default_nettype none
// ============================================================================
// Module      : write_s_block_pixel_clip
// Description : Converts one signed 32-bit S value into an 8-bit pixel.
//               The value is first shifted arithmetically right by S_SHIFT.
//               Macro WS_SATURATE_EN:
//                 defined   - the pixel is clamped to 0..255
//                 undefined - the low 8 bits pass through unchanged (raw
//                             wrap), for bit-exact comparison with the
//                             software transform dump
//   i_s     in  32  signed S value
//   o_pixel out  8  pixel
// Revision    : 1.0 - initial release
// ============================================================================
module write_s_block_pixel_clip
  import write_s_block_pkg::*;
#(
  parameter int S_SHIFT = WS_S_SHIFT
) (
  input  wire logic signed [31:0] i_s,
  output logic             [7:0]  o_pixel
);

  logic signed [31:0] w_v;

  assign w_v = i_s >>> S_SHIFT;

`ifdef WS_SATURATE_EN
  always_comb begin
    if (w_v < 0)
      o_pixel = 8'h00;
    else if (w_v > 32'sd255)
      o_pixel = 8'hFF;
    else
      o_pixel = w_v[7:0];
  end
`else
  logic w_unused_hi;

  assign o_pixel     = w_v[7:0];
  assign w_unused_hi = ^w_v[31:8];
`endif

endmodule
`default_nettype wire

// File: rtl/write_s_block.sv
`default_nettype none
// ============================================================================
// Module      : write_s_block
// Description : Drains one finished 8x8 S block from the DP-RAM and writes it
//               to SRAM as 32 words. Each word holds two pixels, even pixel
//               in the high byte.
//               The sequencer starts this block once per block.
//               Cycle 0 is the cycle in which start is accepted:
//                 - DP addresses are presented in cycles 1..64
//                 - SRAM writes occur in cycles 4,6,...,66
//                 - WS_done pulses in cycle 67
//               Macro WS_SATURATE_EN selects clamping in the pixel converter.
//               Timing is the same with or without it.
//   CLOCK_50_I in  1  clock
//   Resetn     in  1  asynchronous active-low reset
//   bus        slave modport of write_s_block_if:
//                start/done handshake, block_row/block_col,
//                DP-RAM port (read only), SRAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module write_s_block
  import write_s_block_pkg::*;
#(
  parameter int S_BASE     = WS_S_BASE,
  parameter int S_SHIFT    = WS_S_SHIFT,
  parameter int SRAM_BASE  = WS_SRAM_BASE,
  parameter int LINE_WORDS = WS_LINE_WORDS
) (
  input wire logic        CLOCK_50_I,
  input wire logic        Resetn,
  write_s_block_if.slave  bus
);

  ws_state_type r_state;
  ws_state_type w_next;

  logic [5:0]  r_p;           // pixel index of the data arriving this cycle
  logic [4:0]  r_brow;
  logic [5:0]  r_bcol;
  logic [7:0]  r_even_pix;
  sram_addr_t  r_sram_addr;
  logic [15:0] r_sram_data;
  logic        r_we_n;

  dp_addr_t    w_dp_address;
  logic        w_done;
  logic [7:0]  w_pixel;
  sram_addr_t  w_line;
  sram_addr_t  w_pair_addr;

  write_s_block_pixel_clip #(
    .S_SHIFT (S_SHIFT)
  ) u_clip (
    .i_s     (bus.dp_read_data),
    .o_pixel (w_pixel)
  );

  // Pair address for the odd pixel now arriving.
  // Row index = r_p[5:3]. Word within the row = r_p[2:1].
  assign w_line      = 18'(r_brow) * 18'd8 + 18'(r_p[5:3]);
  assign w_pair_addr = 18'(SRAM_BASE) + w_line * 18'(LINE_WORDS)
                     + 18'(r_bcol) * 18'd4 + 18'(r_p[2:1]);

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn)
      r_state <= WS_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_dp_address = 7'(S_BASE);
    w_done       = 1'b0;
    case (r_state)
      WS_IDLE: if (bus.WS_start) w_next = WS_LI;
      WS_LI:   w_next = WS_RUN;
      WS_RUN: begin
        // Prefetch one address ahead of the data being consumed.
        if (r_p != 6'd63)
          w_dp_address = 7'(S_BASE) + {1'b0, r_p} + 7'd1;
        else
          w_next = WS_LO;
      end
      WS_LO:   w_next = WS_DONE;
      WS_DONE: begin
        w_done = 1'b1;
        w_next = WS_IDLE;
      end
      default: w_next = WS_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      r_p         <= 6'd0;
      r_brow      <= 5'd0;
      r_bcol      <= 6'd0;
      r_even_pix  <= 8'd0;
      r_sram_addr <= 18'd0;
      r_sram_data <= 16'd0;
      r_we_n      <= 1'b1;
    end else begin
      r_we_n <= 1'b1;
      if (r_state == WS_IDLE && bus.WS_start) begin
        r_brow <= bus.block_row;
        r_bcol <= bus.block_col;
        r_p    <= 6'd0;
      end
      if (r_state == WS_RUN) begin
        r_p <= r_p + 6'd1;
        if (!r_p[0]) begin
          r_even_pix <= w_pixel;
        end else begin
          r_sram_addr <= w_pair_addr;
          r_sram_data <= {r_even_pix, w_pixel};
          r_we_n      <= 1'b0;
        end
      end
    end
  end

  assign bus.WS_done         = w_done;
  assign bus.dp_address      = w_dp_address;
  assign bus.dp_write_data   = 32'd0;
  assign bus.dp_write_enable = 1'b0;
  assign bus.SRAM_address    = r_sram_addr;
  assign bus.SRAM_write_data = r_sram_data;
  assign bus.SRAM_we_n       = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_write_s_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_s_block
// Description : Self-checking bench for write_s_block.
//               A DP-RAM model supplies S values. A negedge monitor records
//               every SRAM write and every done pulse, with its cycle number.
//               Expected results depend on the WS_SATURATE_EN build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_s_block;

  logic clk = 1'b0;
  logic Resetn;
  always #10 clk = ~clk;

  write_s_block_if bus ();

  write_s_block dut (
    .CLOCK_50_I (clk),
    .Resetn     (Resetn),
    .bus        (bus)
  );

`ifdef WS_SATURATE_EN
  localparam logic [15:0] EXP_NEG = 16'h0000;
  localparam logic [15:0] EXP_300 = 16'hFFFF;
`else
  localparam logic [15:0] EXP_NEG = 16'hFFFF;
  localparam logic [15:0] EXP_300 = 16'h2C2C;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;

  logic [31:0] mem [0:127];
  int          wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          done_cyc[$];
  int          dp_trace[0:79];

  // Synchronous-read DP-RAM model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.dp_read_data <= mem[bus.dp_address];
  end

  always @(negedge clk) begin
    int k;
    if (Resetn) begin
      if (bus.SRAM_we_n === 1'b0) begin
        wr_addr.push_back(int'(bus.SRAM_address));
        wr_data.push_back(bus.SRAM_write_data);
        wr_cyc.push_back(cyc);
      end
      if (bus.WS_done === 1'b1) done_cyc.push_back(cyc);
    end
    k = cyc - c0;
    if (k >= 0 && k < 80) dp_trace[k] = int'(bus.dp_address);
  end

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) mem[64 + i] = 32'(i) << 16;
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < 64; i++) mem[64 + i] = v;
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
    for (int i = 0; i < 80; i++) dp_trace[i] = -1;
  endtask

  // Leaves the bench at the negedge of cycle 1 of the new block
  task automatic start_block(input logic [4:0] row, input logic [5:0] col);
    clear_log();
    @(negedge clk);
    bus.block_row = row;
    bus.block_col = col;
    bus.WS_start  = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus.WS_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit timed_out);
    int t = 0;
    while (done_cyc.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    timed_out = (done_cyc.size() < n);
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.WS_done !== 1'b0 || bus.dp_address !== 7'd64 || bus.SRAM_address !== 18'd0 ||
        bus.SRAM_write_data !== 16'd0 || bus.SRAM_we_n !== 1'b1) begin
      failures++;
      $display("FAIL reset_vals got done=%b dp=%0d sa=%0d sd=%h we_n=%b exp 0 64 0 0000 1",
               bus.WS_done, bus.dp_address, bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n);
    end
    Resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.WS_done !== 1'b0 || bus.SRAM_we_n !== 1'b1 || bus.dp_write_enable !== 1'b0 ||
        bus.dp_write_data !== 32'd0) begin
      failures++;
      $display("FAIL idle_vals got done=%b we_n=%b dpwe=%b dpwd=%h exp 0 1 0 0",
               bus.WS_done, bus.SRAM_we_n, bus.dp_write_enable, bus.dp_write_data);
    end
  endtask

  task automatic test_ramp();
    bit to;
    int ea;
    logic [15:0] ed;
    fill_ramp();
    start_block(5'd0, 6'd0);
    wait_done(1, 200, to);
    checks++;
    if (to) begin failures++; $display("FAIL ramp_timeout got no done exp done"); end
    checks++;
    if (wr_addr.size() != 32) begin
      failures++; $display("FAIL ramp_count got %0d exp 32", wr_addr.size());
    end
    for (int i = 0; i < 32 && i < wr_addr.size(); i++) begin
      ea = (i / 4) * 160 + (i % 4);
      ed = {8'(2 * i), 8'(2 * i + 1)};
      checks++;
      if (wr_addr[i] != ea) begin
        failures++; $display("FAIL ramp_addr[%0d] got %0d exp %0d", i, wr_addr[i], ea);
      end
      checks++;
      if (wr_data[i] !== ed) begin
        failures++; $display("FAIL ramp_data[%0d] got %h exp %h", i, wr_data[i], ed);
      end
      checks++;
      if (wr_cyc[i] - c0 != 4 + 2 * i) begin
        failures++; $display("FAIL ramp_wcyc[%0d] got %0d exp %0d", i, wr_cyc[i] - c0, 4 + 2 * i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - c0 != 67) begin
      failures++;
      $display("FAIL ramp_done got n=%0d cyc=%0d exp n=1 cyc=67", done_cyc.size(),
               done_cyc.size() > 0 ? done_cyc[0] - c0 : -1);
    end
    for (int k = 1; k <= 64; k++) begin
      checks++;
      if (dp_trace[k] != 63 + k) begin
        failures++; $display("FAIL ramp_dpaddr[%0d] got %0d exp %0d", k, dp_trace[k], 63 + k);
      end
    end
  endtask

  task automatic test_const(input string name, input logic [31:0] v, input logic [15:0] ed);
    bit to;
    int bad;
    fill_const(v);
    start_block(5'd0, 6'd0);
    wait_done(1, 200, to);
    checks++;
    if (to || wr_data.size() != 32) begin
      failures++; $display("FAIL %s_count got %0d exp 32", name, wr_data.size());
    end
    bad = 0;
    for (int i = 0; i < wr_data.size(); i++) if (wr_data[i] !== ed) bad++;
    checks++;
    if (bad != 0 || wr_data.size() == 0) begin
      failures++;
      $display("FAIL %s_data got %h (%0d bad) exp %h", name,
               wr_data.size() > 0 ? wr_data[0] : 16'hxxxx, bad, ed);
    end
  endtask

  task automatic test_corner();
    bit to;
    fill_ramp();
    start_block(5'd29, 6'd39);
    wait_done(1, 200, to);
    checks++;
    if (to || wr_addr.size() != 32) begin
      failures++; $display("FAIL corner_count got %0d exp 32", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] != 37276) begin
        failures++; $display("FAIL corner_first got %0d exp 37276", wr_addr[0]);
      end
      checks++;
      if (wr_addr[31] != 38399) begin
        failures++; $display("FAIL corner_last got %0d exp 38399", wr_addr[31]);
      end
    end
  endtask

  task automatic test_midreset();
    bit to;
    fill_ramp();
    start_block(5'd0, 6'd0);
    repeat (19) @(negedge clk);  // cycle 20: a write is in progress
    checks++;
    if (bus.SRAM_we_n !== 1'b0) begin
      failures++; $display("FAIL mr_prewrite got we_n=%b exp 0", bus.SRAM_we_n);
    end
    Resetn = 1'b0;
    #1;
    checks++;
    if (bus.SRAM_we_n !== 1'b1 || bus.WS_done !== 1'b0) begin
      failures++;
      $display("FAIL mr_async got we_n=%b done=%b exp 1 0", bus.SRAM_we_n, bus.WS_done);
    end
    repeat (3) @(negedge clk);
    Resetn = 1'b1;
    repeat (80) @(negedge clk);
    checks++;
    if (done_cyc.size() != 0) begin
      failures++; $display("FAIL mr_nodone got %0d pulses exp 0", done_cyc.size());
    end
    start_block(5'd0, 6'd0);
    wait_done(1, 200, to);
    checks++;
    if (to || wr_data.size() != 32) begin
      failures++; $display("FAIL mr_redo_count got %0d exp 32", wr_data.size());
    end else begin
      checks++;
      if (wr_data[0] !== 16'h0001 || wr_data[31] !== 16'h3E3F || wr_addr[31] != 1123) begin
        failures++;
        $display("FAIL mr_redo_data got %h %h @%0d exp 0001 3e3f @1123",
                 wr_data[0], wr_data[31], wr_addr[31]);
      end
    end
  endtask

  task automatic test_ignore_start();
    bit to;
    fill_ramp();
    start_block(5'd1, 6'd2);
    repeat (9) @(negedge clk);       // cycle 10
    bus.WS_start = 1'b1; bus.block_row = 5'd5; bus.block_col = 6'd7;
    @(negedge clk);
    bus.WS_start = 1'b0;
    repeat (29) @(negedge clk);      // cycle 40
    bus.WS_start = 1'b1;
    @(negedge clk);
    bus.WS_start = 1'b0;
    wait_done(1, 200, to);
    repeat (80) @(negedge clk);
    checks++;
    if (to || done_cyc.size() != 1 || wr_addr.size() != 32) begin
      failures++;
      $display("FAIL ign_counts got done=%0d writes=%0d exp 1 32", done_cyc.size(), wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] != 1288 || wr_addr[31] != 2411) begin
        failures++;
        $display("FAIL ign_addr got %0d..%0d exp 1288..2411", wr_addr[0], wr_addr[31]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    fill_ramp();
    clear_log();
    @(negedge clk);
    bus.block_row = 5'd0; bus.block_col = 6'd0; bus.WS_start = 1'b1;
    c0 = cyc;
    repeat (70) @(negedge clk);      // held through done; restart at cycle 68
    bus.WS_start = 1'b0;
    wait_done(2, 200, to);
    checks++;
    if (to || done_cyc.size() != 2 || wr_cyc.size() != 64) begin
      failures++;
      $display("FAIL b2b_counts got done=%0d writes=%0d exp 2 64", done_cyc.size(), wr_cyc.size());
    end else begin
      checks++;
      if (done_cyc[1] - c0 != 135 || wr_cyc[32] - c0 != 72) begin
        failures++;
        $display("FAIL b2b_timing got done=%0d wr=%0d exp 135 72",
                 done_cyc[1] - c0, wr_cyc[32] - c0);
      end
    end
  endtask

  initial begin
    bus.WS_start     = 1'b0;
    bus.block_row    = 5'd0;
    bus.block_col    = 6'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    test_reset();
    test_ramp();
    test_const("neg", 32'hFFFF0000, EXP_NEG);
    test_const("big", 32'd300 << 16, EXP_300);
    test_corner();
    test_midreset();
    test_ignore_start();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
